// File: rtl/ring_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_arbiter
//  Description : N-way round-robin arbiter with a one-hot ring-counter
//                priority pointer, a bounded hold time per ownership and a
//                mandatory two-cycle zero-grant gap between ownerships.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] grant_out,
  output logic [N-1:0] ptr_out,
  output logic         busy_out,
  output logic         timeout_out
);

  // Hold counter is sized to reach MAX_HOLD exactly, so it never wraps.
  localparam int              CW         = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]   c_HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0]   c_HOLD_ONE = CW'(1);
  localparam logic [N-1:0]    c_PTR_RST  = N'(1);
  localparam logic [2*N-1:0]  c_DBL_ONE  = (2 * N)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [N-1:0]    r_ptr;
  logic [CW-1:0]   r_hold;
  logic            r_timeout;

  logic [2*N-1:0]  w_masked;
  logic [2*N-1:0]  w_lowest;
  logic [N-1:0]    w_winner;
  logic [N-1:0]    w_winner_rot;
  logic            w_owner_req;

  // Cyclic priority search: the lower copy keeps only requests at or above
  // the pointer position, the upper copy holds all requests so the search
  // wraps to bit 0 when nothing at or above the pointer is asking.
  assign w_masked     = {req_in, req_in & ~(r_ptr - c_PTR_RST)};
  assign w_lowest     = w_masked & (~w_masked + c_DBL_ONE);
  assign w_winner     = w_lowest[N-1:0] | w_lowest[2*N-1:N];
  assign w_winner_rot = {w_winner[N-2:0], w_winner[N-1]};

  // The owner still requesting (grant is one-hot in OWN).
  assign w_owner_req  = |(req_in & r_grant);

  // Arbitration FSM with all outputs registered; reset clears grant at once.
  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ptr     <= c_PTR_RST;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timeout <= 1'b0;
          if (|req_in) begin
            r_grant <= w_winner;
            r_ptr   <= w_winner_rot;
            r_hold  <= c_HOLD_ONE;
            r_state <= S_OWN;
          end
        end

        S_OWN: begin
          if (!w_owner_req) begin
            // Voluntary release.
            r_grant   <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
            r_state   <= S_GAP;
          end else if (r_hold == c_HOLD_MAX) begin
            // Forced release after MAX_HOLD grant cycles.
            r_grant   <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_GAP;
          end else begin
            r_hold    <= r_hold + c_HOLD_ONE;
            r_timeout <= 1'b0;
          end
        end

        S_GAP: begin
          r_timeout <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_grant   <= '0;
          r_hold    <= '0;
          r_timeout <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_out   = r_grant;
  assign ptr_out     = r_ptr;
  assign busy_out    = (r_state == S_OWN);
  assign timeout_out = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ring_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_arbiter
//  Description : Self-checking bench for ring_arbiter against an index-based
//                behavioural model, with directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] ptr;
  logic         busy;
  logic         tmo;

  int n_checks;
  int n_fail;

  // Behavioural model: phase 0 = idle, 1 = owning, 2 = gap.
  int m_phase;
  int m_owner;
  int m_ptr_idx;
  int m_hold;
  int m_to;
  logic prev_to;

  ring_arbiter #(.N(N), .MAX_HOLD(MH)) u_dut (
    .clk         (clk),
    .reset_ah_in (rst),
    .req_in      (req),
    .grant_out   (grant),
    .ptr_out     (ptr),
    .busy_out    (busy),
    .timeout_out (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_owner   = 0;
    m_ptr_idx = 0;
    m_hold    = 0;
    m_to      = 0;
    prev_to   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    case (m_phase)
      0: begin
        m_to = 0;
        if (r != '0) begin
          for (int o = 0; o < N; o++) begin
            if (r[(m_ptr_idx + o) % N]) begin
              m_owner = (m_ptr_idx + o) % N;
              break;
            end
          end
          m_ptr_idx = (m_owner + 1) % N;
          m_hold    = 1;
          m_phase   = 1;
        end
      end
      1: begin
        if (!r[m_owner]) begin
          m_phase = 2; m_to = 0;
        end else if (m_hold == MH) begin
          m_phase = 2; m_to = 1;
        end else begin
          m_hold++; m_to = 0;
        end
      end
      default: begin
        m_phase = 0; m_to = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    logic [N-1:0] ep;
    eg = (m_phase == 1) ? N'(1 << m_owner) : '0;
    ep = N'(1 << m_ptr_idx);
    check("grant", 32'(grant), 32'(eg));
    check("ptr", 32'(ptr), 32'(ep));
    check("busy", 32'(busy), 32'(m_phase == 1));
    check("timeout", 32'(tmo), 32'(m_to));
    check("inv_ptr_onehot", 32'($onehot(ptr)), 32'd1);
    check("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("inv_busy_eq_grant", 32'(busy), 32'(|grant));
    check("inv_timeout_pulse", 32'(prev_to & tmo), 32'd0);
    prev_to = tmo;
  endtask

  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(tmo), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] r;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    model_reset();
    #3;
    do_reset();

    // Single request, then voluntary release.
    cycle(4'b0100);
    check("single_grant", 32'(grant), 32'h4);
    check("single_ptr", 32'(ptr), 32'h8);
    cycle(4'b0000);
    check("release_grant", 32'(grant), 32'h0);
    check("release_timeout", 32'(tmo), 32'h0);
    cycle(4'b0000);

    // Wrap-around from pointer 1000.
    cycle(4'b0011);
    check("wrap_grant", 32'(grant), 32'h1);
    check("wrap_ptr", 32'(ptr), 32'h2);
    cycle(4'b0000);
    cycle(4'b0000);

    // No preemption while 0010 owns.
    cycle(4'b0010);
    check("own_grant", 32'(grant), 32'h2);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111);
      check("nopre_grant", 32'(grant), 32'h2);
      check("nopre_ptr", 32'(ptr), 32'h4);
    end

    // Asynchronous reset mid-ownership while grant is 0100.
    cycle(4'b0000);
    cycle(4'b0000);
    cycle(4'b0000);
    cycle(4'b0100);
    check("pre_rst_grant", 32'(grant), 32'h4);
    #2;
    do_reset();

    // Full-request rotation with timeouts: 8 grant cycles then 2 zero cycles.
    for (int k = 0; k < 50; k++) begin
      cycle(4'b1111);
      check("rot_grant", 32'(grant),
            (k % 10 < 8) ? 32'(1 << ((k / 10) % N)) : 32'd0);
      check("rot_timeout", 32'(tmo), 32'((k % 10) == 8));
    end

    // Random traffic; the owner usually keeps requesting.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      r = N'($urandom);
      if (m_phase == 1 && $urandom_range(0, 99) < 85) r[m_owner] = 1'b1;
      cycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters; SHALL be >= 2.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per ownership; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_ah_in  input  1  reset, asynchronous and active-high.
REQ-005 req_in  input  N  per-requester request, level-sensitive; the owner holds it high for the whole ownership.
REQ-006 grant_out  output  N  one-hot grant, or all zero; registered.
REQ-007 ptr_out  output  N  one-hot ring-counter priority pointer, registered; the set bit marks the highest-priority requester.
REQ-008 busy_out  output  1  high exactly when grant_out is non-zero.
REQ-009 timeout_out  output  1  one-cycle pulse marking a forced release.

Function
REQ-010 The FSM SHALL have three states: IDLE, OWN and GAP.
REQ-011 IDLE, req_in == 0: SHALL stay in IDLE; grant_out and ptr_out SHALL be unchanged.
REQ-012 IDLE, req_in != 0: the winner SHALL be the first set req_in bit, searching cyclically upward from the ptr_out bit position, with wrap from bit N-1 to bit 0.
REQ-013 On that edge the block SHALL set grant_out = winner, ptr_out = winner rotated left by 1 (bit N-1 wraps to bit 0), hold count = 1, and state = OWN.
REQ-014 Latency: grant_out SHALL appear in the cycle after the edge that sampled req_in in IDLE. There SHALL be no combinational path from req_in to any output.
REQ-015 OWN, req_in[owner] == 0 at an edge: grant_out SHALL become 0 and state SHALL become GAP, with timeout_out low.
REQ-016 OWN, req_in[owner] == 1 and hold count == MAX_HOLD: grant_out SHALL become 0, state SHALL become GAP, and timeout_out SHALL be 1 for the GAP cycle only.
REQ-017 OWN, otherwise: the hold count SHALL increment and grant_out SHALL be held.
REQ-018 A held request therefore keeps its grant for exactly MAX_HOLD cycles.
REQ-019 The hold counter width SHALL be clog2(MAX_HOLD+1) bits and it SHALL never wrap.
REQ-020 Requests from non-owners during OWN SHALL NOT preempt the owner or change ptr_out.
REQ-021 GAP SHALL last exactly one cycle with grant_out = 0, then go to IDLE unconditionally.
REQ-022 The minimum gap between consecutive grants SHALL be two zero-grant cycles (GAP, then IDLE).
REQ-023 If a timed-out requester keeps req_in high, it SHALL re-compete normally; the rotated ptr_out gives other requesters priority.
REQ-024 ptr_out SHALL always be exactly one-hot. grant_out SHALL always be zero or one-hot.
REQ-025 busy_out SHALL equal (state == OWN).

Reset
REQ-026 While reset_ah_in = 1, regardless of clk: state = IDLE, grant_out = 0, ptr_out = 1 (bit 0), hold count = 0, busy_out = 0, timeout_out = 0.
REQ-027 Assertion mid-ownership SHALL clear grant_out immediately, without waiting for a clock edge.
REQ-028 After deassertion, the first arbitration SHALL occur on the first rising edge that samples reset_ah_in = 0.

Verification
REQ-029 Reset: assert reset_ah_in mid-cycle while grant_out = 0100 -> grant_out = 0000, ptr_out = 0001, busy_out = 0 before the next edge.
REQ-030 Single request: N=4, ptr_out = 0001, req_in = 0100 sampled in IDLE -> next cycle grant_out = 0100, ptr_out = 1000; drop req_in[2] -> grant_out = 0000 after the following edge, timeout_out stays 0.
REQ-031 Wrap-around: ptr_out = 1000, req_in = 0011 -> grant_out = 0001, ptr_out = 0010.
REQ-032 Timeout rotation: N=4, MAX_HOLD=8, req_in = 1111 held -> grants 0001, 0010, 0100, 1000, 0001, each 8 cycles long, separated by 2 zero cycles, with one timeout_out pulse per release.
REQ-033 No preemption: owner 0010 active and req_in changes to 1111 -> grant_out stays 0010 and ptr_out stays 0100 until release.
REQ-034 Invariants checked every cycle: ptr_out is one-hot, grant_out is zero or one-hot, busy_out == |grant_out, and timeout_out is never high on two consecutive cycles.
